// File: rtl/sram_host_ctrl.sv
// Host-side sequencer for a synchronous SRAM bus: single-beat read/write requests
// in, registered chip-select/write-enable/address/tristate data out, read data back.
module sram_host_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int TA_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              we_n,
    output logic              cs_n
);

    typedef enum logic [1:0] {IDLE, CMD, RD_WAIT, TURN} state_t;

    // Terminal counts for the read-wait and turnaround phases (counter starts at 0).
    localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
    localparam logic [1:0] TA_LAST = 2'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);

    state_t            state_reg, state_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              we_lat_reg, we_lat_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              cs_n_reg, cs_n_next;
    logic              we_n_reg, we_n_next;
    logic              oe_reg, oe_next;
    logic              req_ready_reg, req_ready_next;
    logic              rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            we_lat_reg    <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cs_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            oe_reg        <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_lat_reg    <= we_lat_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cs_n_reg      <= cs_n_next;
            we_n_reg      <= we_n_next;
            oe_reg        <= oe_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    // Bus controls are computed one cycle ahead so every SRAM-facing pin comes from a flop.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        we_lat_next    = we_lat_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cs_n_next      = 1'b1;
        we_n_next      = 1'b1;
        oe_next        = 1'b0;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid && req_ready_reg) begin
                    state_next  = CMD;
                    we_lat_next = req_we;
                    addr_next   = req_addr;
                    wdata_next  = req_wdata;
                    cs_n_next   = 1'b0;
                    we_n_next   = !req_we;
                    oe_next     = req_we;
                end
            end
            CMD: begin
                cnt_next   = '0;
                state_next = we_lat_reg ? IDLE : RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_reg == RD_LAST) begin
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = data;
                    cnt_next       = '0;
                    state_next     = (TA_CYCLES == 0) ? IDLE : TURN;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            TURN: begin
                if (cnt_reg == TA_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        req_ready_next = (state_next == IDLE);
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_data_drv
            assign data[gi] = oe_reg ? wdata_reg[gi] : 1'bz;
        end
    endgenerate

    assign addr      = addr_reg;
    assign cs_n      = cs_n_reg;
    assign we_n      = we_n_reg;
    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_sram_host_ctrl.sv
// Bench for sram_host_ctrl: two instances (RD_LAT=1/TA=1 and RD_LAT=3/TA=0), each on
// its own behavioural SRAM, driven by directed vector tables plus reset corner cases.
module tb_sram_host_ctrl;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_cnt_a = 0;
    int rsp_cnt_b = 0;

    always #5 clk = ~clk;

    logic        req_valid_a, req_valid_b, req_ready_a, req_ready_b;
    logic        rsp_valid_a, rsp_valid_b, we_n_a, we_n_b, cs_n_a, cs_n_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b, addr_a, addr_b;
    wire  [31:0] data_a, data_b;

    assign req_valid_a = req_valid & ~sel;
    assign req_valid_b = req_valid & sel;

    sram_host_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .TA_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .addr(addr_a),
        .data(data_a), .we_n(we_n_a), .cs_n(cs_n_a)
    );

    sram_host_ctrl #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .TA_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .addr(addr_b),
        .data(data_b), .we_n(we_n_b), .cs_n(cs_n_b)
    );

    // SRAM models: write on the command edge, drive read data for exactly cycle C+RD_LAT.
    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    logic        rd_pipe_a = 1'b0;
    logic [2:0]  rd_pipe_b = 3'b000;
    logic [31:0] rd_val_a = '0;
    logic [31:0] rd_val_b = '0;

    always @(posedge clk) begin
        rd_pipe_a <= !cs_n_a && we_n_a;
        if (!cs_n_a && !we_n_a) mem_a[addr_a[7:0]] <= data_a;
        if (!cs_n_a && we_n_a)  rd_val_a <= mem_a[addr_a[7:0]];
    end
    assign data_a = rd_pipe_a ? rd_val_a : 'z;

    always @(posedge clk) begin
        rd_pipe_b <= {rd_pipe_b[1:0], (!cs_n_b && we_n_b)};
        if (!cs_n_b && !we_n_b) mem_b[addr_b[7:0]] <= data_b;
        if (!cs_n_b && we_n_b)  rd_val_b <= mem_b[addr_b[7:0]];
    end
    assign data_b = rd_pipe_b[2] ? rd_val_b : 'z;

    always @(negedge clk) begin
        if (rsp_valid_a === 1'b1) rsp_cnt_a++;
        if (rsp_valid_b === 1'b1) rsp_cnt_b++;
    end

    // View of whichever instance is under test.
    wire        o_ready     = sel ? req_ready_b : req_ready_a;
    wire        o_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    wire [31:0] o_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;
    wire [31:0] o_addr      = sel ? addr_b : addr_a;
    wire        o_cs_n      = sel ? cs_n_b : cs_n_a;
    wire        o_we_n      = sel ? we_n_b : we_n_a;
    wire [31:0] o_data      = sel ? data_b : data_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    task automatic present(input vec_t v);
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
    endtask

    // Holds the request until accepted; returns in the command cycle C.
    task automatic issue(input vec_t v);
        present(v);
        for (int i = 0; i < 20; i++) begin
            if (o_ready) begin
                tick();
                req_valid = 1'b0;
                return;
            end
            tick();
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: actual=no accept required=accept within 20 cycles (addr=%h)", v.addr);
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input bit has_next, input vec_t nxt);
        int rl;
        int ta;
        logic [31:0] mem_val;
        rl = sel ? 3 : 1;
        ta = sel ? 0 : 1;
        issue(v);
        check("cmd_cs_n", o_cs_n, 0);
        check("cmd_we_n", o_we_n, !v.we);
        check("cmd_addr", o_addr, v.addr);
        check("cmd_ready", o_ready, 0);
        check("cmd_rsp_valid", o_rsp_valid, 0);
        if (v.we) check("cmd_wdata", o_data, v.wdata);
        else      check("cmd_bus_z", $countones(o_data), 0);
        tick();
        if (v.we) begin
            mem_val = sel ? mem_b[v.addr[7:0]] : mem_a[v.addr[7:0]];
            check("wr_ready_next", o_ready, 1);
            check("wr_cs_n_next", o_cs_n, 1);
            check("wr_we_n_next", o_we_n, 1);
            check("wr_bus_z_next", $countones(o_data), 0);
            check("wr_mem", mem_val, v.wdata);
            $display("txn sel=%0d WR addr=%h data=%h", sel, v.addr, v.wdata);
        end else begin
            for (int k = 1; k <= rl; k++) begin
                check("rdw_rsp_valid", o_rsp_valid, 0);
                check("rdw_cs_n", o_cs_n, 1);
                check("rdw_we_n", o_we_n, 1);
                check("rdw_ready", o_ready, 0);
                if (k < rl) tick();
            end
            tick();
            check("rsp_valid", o_rsp_valid, 1);
            check("rsp_rdata", o_rsp_rdata, v.exp_rdata);
            check("rsp_ready", o_ready, (ta == 0));
            check("rsp_bus_z", $countones(o_data), 0);
            $display("txn sel=%0d RD addr=%h data=%h", sel, v.addr, o_rsp_rdata);
            // Next request is presented during turnaround and must be held off.
            if (has_next) present(nxt);
            for (int j = 2; j <= ta; j++) begin
                tick();
                check("turn_ready", o_ready, 0);
                check("turn_bus_z", $countones(o_data), 0);
            end
            if (ta > 0) begin
                tick();
                check("turn_end_ready", o_ready, 1);
                check("turn_end_rsp_valid", o_rsp_valid, 0);
                check("turn_end_cs_n", o_cs_n, 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl_a [10];
        vec_t tbl_b [5];
        vec_t v;
        int   exp_rsp_a;
        int   exp_rsp_b;

        tbl_a[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        tbl_a[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tbl_a[2] = '{1'b1, 32'h0000_0004, 32'h1111_1111, 32'h0};
        tbl_a[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111};
        tbl_a[4] = '{1'b1, 32'h0000_0008, 32'h2222_2222, 32'h0};
        tbl_a[5] = '{1'b0, 32'h0000_0008, 32'h0,         32'h2222_2222};
        tbl_a[6] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        tbl_a[7] = '{1'b1, 32'h8000_0020, 32'hA5A5_5A5A, 32'h0};
        tbl_a[8] = '{1'b0, 32'h8000_0020, 32'h0,         32'hA5A5_5A5A};
        tbl_a[9] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1111_1111};

        tbl_b[0] = '{1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0};
        tbl_b[1] = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D};
        tbl_b[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D};
        tbl_b[3] = '{1'b1, 32'hFFFF_FF44, 32'h0BAD_C0DE, 32'h0};
        tbl_b[4] = '{1'b0, 32'hFFFF_FF44, 32'h0,         32'h0BAD_C0DE};

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        // Power-on reset.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_cs_n", o_cs_n, 1);
        check("rst_we_n", o_we_n, 1);
        check("rst_addr", o_addr, 0);
        check("rst_ready", o_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_rdata", o_rsp_rdata, 0);
        check("rst_bus_z", $countones(o_data), 0);
        rst = 1'b0;
        check("rel_ready_before_edge", o_ready, 0);
        tick();
        check("rel_ready_after_edge", o_ready, 1);

        // Instance A: RD_LAT=1, TA_CYCLES=1.
        sel = 1'b0;
        exp_rsp_a = 0;
        for (int i = 0; i < 10; i++) begin
            if (!tbl_a[i].we) exp_rsp_a++;
            run_txn(tbl_a[i], (i + 1 < 10), tbl_a[(i + 1) % 10]);
        end

        // Reset during a write command cycle: bus released without a clock edge, no write lands.
        v = '{1'b1, 32'h0000_0030, 32'h1234_5678, 32'h0};
        issue(v);
        check("mw_cmd_cs_n", o_cs_n, 0);
        rst = 1'b1;
        #1;
        check("mw_async_cs_n", o_cs_n, 1);
        check("mw_async_we_n", o_we_n, 1);
        check("mw_async_bus_z", $countones(o_data), 0);
        check("mw_async_ready", o_ready, 0);
        check("mw_async_addr", o_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mw_ready_after", o_ready, 1);
        check("mw_mem_untouched", mem_a[8'h30], 0);
        $display("txn sel=0 WR addr=%h aborted by reset", v.addr);

        // Reset during RD_WAIT: read dropped, rsp_rdata cleared, later read still correct.
        v = '{1'b0, 32'h0000_0004, 32'h0, 32'h1111_1111};
        issue(v);
        tick();
        rst = 1'b1;
        #1;
        check("mr_async_cs_n", o_cs_n, 1);
        check("mr_async_we_n", o_we_n, 1);
        check("mr_async_ready", o_ready, 0);
        check("mr_async_rsp_valid", o_rsp_valid, 0);
        check("mr_async_rsp_rdata", o_rsp_rdata, 0);
        tick();
        check("mr_no_rsp", o_rsp_valid, 0);
        rst = 1'b0;
        tick();
        check("mr_ready_after", o_ready, 1);
        check("mr_no_rsp_after", o_rsp_valid, 0);
        check("mr_rdata_after", o_rsp_rdata, 0);
        $display("txn sel=0 RD addr=%h dropped by reset", v.addr);
        run_txn(v, 1'b0, v);
        exp_rsp_a++;

        // Instance B: RD_LAT=3, TA_CYCLES=0.
        sel = 1'b1;
        tick();
        exp_rsp_b = 0;
        for (int i = 0; i < 5; i++) begin
            if (!tbl_b[i].we) exp_rsp_b++;
            run_txn(tbl_b[i], (i + 1 < 5), tbl_b[(i + 1) % 5]);
        end
        tick();
        check("b_idle_rsp_valid", o_rsp_valid, 0);
        check("b_idle_ready", o_ready, 1);

        repeat (2) tick();
        check("rsp_pulses_a", rsp_cnt_a, exp_rsp_a);
        check("rsp_pulses_b", rsp_cnt_b, exp_rsp_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
